// File: rtl/blake2_pkg.sv
// blake2_pkg: BLAKE2 constants, message schedule, G index table and FSM state type
package blake2_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_e;
  // SIGMA[r][j] is nibble j of row r, counted from the most significant nibble
  localparam logic [63:0] SIGMA [10] = '{
    64'h0123456789abcdef,
    64'hea489fd61c02b753,
    64'hb8c052fdae367194,
    64'h7931dcbe265a40f8,
    64'h905724afe1bc683d,
    64'h2c6a0b834d75fe19,
    64'hc51fed4a0763928b,
    64'hdb7ec13950f4862a,
    64'h6fe9b308c2d714a5,
    64'ha2847615fb9e3cd0
  };
  localparam logic [63:0] IV64 [8] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };
  localparam logic [31:0] IV32 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  // {a,b,c,d} state indices for G 0..7: four columns then four diagonals
  localparam logic [15:0] GIDX [8] = '{
    16'h048c, 16'h159d, 16'h26ae, 16'h37bf,
    16'h05af, 16'h16bc, 16'h278d, 16'h349e
  };
  function automatic int rot(input int w, input int i);
    return (w == 64) ? ((i == 0) ? 32 : (i == 1) ? 24 : (i == 2) ? 16 : 63)
                     : ((i == 0) ? 16 : (i == 1) ? 12 : (i == 2) ? 8 : 7);
  endfunction
  function automatic logic [63:0] iv(input int w, input logic [2:0] i);
    return (w == 64) ? IV64[i] : {32'h0, IV32[i]};
  endfunction
  function automatic logic [3:0] sigma(input logic [3:0] r, input logic [3:0] j);
    logic [63:0] s;
    s = SIGMA[r] << {j, 2'b00};
    return s[63:60];
  endfunction
endpackage

// File: rtl/blake2_g.sv
// blake2_g: combinational BLAKE2 G mixing function for word width W
module blake2_g
  import blake2_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  input  logic [W-1:0] d_i,
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  output logic [W-1:0] a_o,
  output logic [W-1:0] b_o,
  output logic [W-1:0] c_o,
  output logic [W-1:0] d_o
);
  localparam int R0 = rot(W, 0);
  localparam int R1 = rot(W, 1);
  localparam int R2 = rot(W, 2);
  localparam int R3 = rot(W, 3);
  function automatic logic [W-1:0] ror(input logic [W-1:0] v, input int n);
    return (v >> n) | (v << (W - n));
  endfunction
  logic [W-1:0] a1, b1, c1, d1;
  assign a1  = a_i + b_i + x_i;
  assign d1  = ror(d_i ^ a1, R0);
  assign c1  = c_i + d1;
  assign b1  = ror(b_i ^ c1, R1);
  assign a_o = a1 + b1 + y_i;
  assign d_o = ror(d1 ^ a_o, R2);
  assign c_o = c1 + d_o;
  assign b_o = ror(b1 ^ c_o, R3);
endmodule

// File: rtl/blake2_compress_iter.sv
// blake2_compress_iter: iterative BLAKE2 F with G_PAR G units per cycle; BLAKE2_CMP_CNT_EN adds the cmp_cnt counter
module blake2_compress_iter
  import blake2_pkg::*;
#(
  parameter int W      = 64,
  parameter int ROUNDS = (W == 64) ? 12 : 10,
  parameter int G_PAR  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [8*W-1:0] h_in,
  input  logic [16*W-1:0] m_in,
  input  logic [2*W-1:0] t_in,
  input  logic           last_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [8*W-1:0] h_out,
  output logic [31:0]    cmp_cnt
);
  localparam int SLOTS = 8 / G_PAR;
  if (!((W == 32 || W == 64) && (G_PAR == 1 || G_PAR == 2 || G_PAR == 4))) begin : g_bad
    $error("blake2_compress_iter: illegal W or G_PAR");
  end
  state_e         state_q, state_d;
  logic [W-1:0]   v_q [16], v_d [16];
  logic [W-1:0]   h_q [8], h_d [8];
  logic [W-1:0]   m_q [16], m_d [16];
  logic [8*W-1:0] h_out_q, h_out_d;
  logic           out_valid_q, out_valid_d;
  logic [2:0]     slot_q, slot_d;
  logic [7:0]     round_q, round_d;
  logic [3:0]     sig_q, sig_d;
  logic [15:0]    gix [G_PAR];
  logic [W-1:0]   ga [G_PAR], gb [G_PAR], gc [G_PAR], gd [G_PAR], gx [G_PAR], gy [G_PAR];
  logic [W-1:0]   na [G_PAR], nb [G_PAR], nc [G_PAR], nd [G_PAR];
  // Slot s runs G indices s*G_PAR.., so every column G finishes before any diagonal G
  for (genvar p = 0; p < G_PAR; p++) begin : g_par
    logic [2:0] k;
    assign k      = 3'(slot_q * G_PAR + p);
    assign gix[p] = GIDX[k];
    assign ga[p]  = v_q[gix[p][15:12]];
    assign gb[p]  = v_q[gix[p][11:8]];
    assign gc[p]  = v_q[gix[p][7:4]];
    assign gd[p]  = v_q[gix[p][3:0]];
    assign gx[p]  = m_q[sigma(sig_q, {k, 1'b0})];
    assign gy[p]  = m_q[sigma(sig_q, {k, 1'b1})];
    blake2_g #(.W(W)) u_g (
      .a_i(ga[p]), .b_i(gb[p]), .c_i(gc[p]), .d_i(gd[p]), .x_i(gx[p]), .y_i(gy[p]),
      .a_o(na[p]), .b_o(nb[p]), .c_o(nc[p]), .d_o(nd[p])
    );
  end
  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    h_d         = h_q;
    m_d         = m_q;
    h_out_d     = h_out_q;
    out_valid_d = out_valid_q;
    slot_d      = slot_q;
    round_d     = round_q;
    sig_d       = sig_q;
    case (state_q)
      IDLE: if (in_valid) begin
        for (int i = 0; i < 8; i++) begin
          h_d[i]     = h_in[i*W +: W];
          v_d[i]     = h_in[i*W +: W];
          v_d[i + 8] = W'(iv(W, 3'(i)));
        end
        for (int j = 0; j < 16; j++) m_d[j] = m_in[j*W +: W];
        v_d[12] = v_d[12] ^ t_in[W-1:0];
        v_d[13] = v_d[13] ^ t_in[2*W-1:W];
        v_d[14] = v_d[14] ^ {W{last_in}};
        slot_d  = '0;
        round_d = '0;
        sig_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        for (int p = 0; p < G_PAR; p++) begin
          v_d[gix[p][15:12]] = na[p];
          v_d[gix[p][11:8]]  = nb[p];
          v_d[gix[p][7:4]]   = nc[p];
          v_d[gix[p][3:0]]   = nd[p];
        end
        slot_d = (slot_q == 3'(SLOTS - 1)) ? 3'd0 : slot_q + 3'd1;
        if (slot_q == 3'(SLOTS - 1)) begin
          round_d = round_q + 8'd1;
          sig_d   = (sig_q == 4'd9) ? 4'd0 : sig_q + 4'd1;
          state_d = (round_q == 8'(ROUNDS - 1)) ? FINAL : RUN;
        end
      end
      FINAL: begin
        for (int i = 0; i < 8; i++) h_out_d[i*W +: W] = h_q[i] ^ v_q[i] ^ v_q[i + 8];
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      h_out_q     <= '0;
      out_valid_q <= 1'b0;
      slot_q      <= '0;
      round_q     <= '0;
      sig_q       <= '0;
    end else begin
      state_q     <= state_d;
      h_out_q     <= h_out_d;
      out_valid_q <= out_valid_d;
      slot_q      <= slot_d;
      round_q     <= round_d;
      sig_q       <= sig_d;
    end
  end
  always_ff @(posedge clk) begin
    v_q <= v_d;
    h_q <= h_d;
    m_q <= m_d;
  end
  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign h_out     = h_out_q;
`ifdef BLAKE2_CMP_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  assign cnt_d = (out_valid_q && out_ready) ? cnt_q + 32'd1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cmp_cnt = cnt_q;
`else
  assign cmp_cnt = '0;
`endif
endmodule

// File: tb/tb_blake2_compress_iter.sv
// tb_blake2_compress_iter: directed known-answer, latency, backpressure, reset and chaining checks
module tb_blake2_compress_iter;
`ifdef BLAKE2_CMP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam logic [63:0] IV [8] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };
  localparam logic [63:0] SG [10] = '{
    64'h0123456789abcdef, 64'hea489fd61c02b753, 64'hb8c052fdae367194, 64'h7931dcbe265a40f8,
    64'h905724afe1bc683d, 64'h2c6a0b834d75fe19, 64'hc51fed4a0763928b, 64'hdb7ec13950f4862a,
    64'h6fe9b308c2d714a5, 64'ha2847615fb9e3cd0
  };
  localparam logic [511:0] ABC_B = {
    64'h239900D4ED8623B9, 64'h5A92F1DBA88AD318, 64'h95CC3345DED552C2, 64'h2D79AB2A39C5877D,
    64'hD1A2FFDB6FBB124B, 64'hB7C45A68142F214C, 64'hE9F6129FB697276A, 64'h0D4D1C983FA580BA
  };
  localparam logic [255:0] ABC_S = {
    32'h82596786, 32'h4C9B994D, 32'h293AD69E, 32'h208B4537,
    32'h2F45EB4E, 32'hA32BA7E1, 32'hE2147C32, 32'h8C5E8C50
  };
  logic clk = 1'b0;
  logic rst;
  logic a_iv, a_or, a_last, a_ir, a_ov;
  logic [511:0] a_h, a_ho;
  logic [1023:0] a_m;
  logic [127:0] a_t;
  logic [31:0] a_cnt;
  logic s_iv;
  logic g1_ir, g1_ov, g2_ir, g2_ov, s_ir, s_ov;
  logic [511:0] g1_ho, g2_ho;
  logic [31:0] g1_cnt, g2_cnt, s_cnt;
  logic [255:0] b_h, s_ho;
  logic [511:0] b_m;
  logic [63:0] b_t;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  blake2_compress_iter #(.W(64), .G_PAR(4)) u_main (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .h_in(a_h), .m_in(a_m), .t_in(a_t),
    .last_in(a_last), .out_valid(a_ov), .out_ready(a_or), .h_out(a_ho), .cmp_cnt(a_cnt));
  blake2_compress_iter #(.W(64), .G_PAR(1)) u_g1 (
    .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(g1_ir), .h_in(a_h), .m_in(a_m), .t_in(a_t),
    .last_in(a_last), .out_valid(g1_ov), .out_ready(1'b1), .h_out(g1_ho), .cmp_cnt(g1_cnt));
  blake2_compress_iter #(.W(64), .G_PAR(2)) u_g2 (
    .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(g2_ir), .h_in(a_h), .m_in(a_m), .t_in(a_t),
    .last_in(a_last), .out_valid(g2_ov), .out_ready(1'b1), .h_out(g2_ho), .cmp_cnt(g2_cnt));
  blake2_compress_iter #(.W(32)) u_s (
    .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(s_ir), .h_in(b_h), .m_in(b_m), .t_in(b_t),
    .last_in(1'b1), .out_valid(s_ov), .out_ready(1'b1), .h_out(s_ho), .cmp_cnt(s_cnt));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_out(output int n);
    n = 0;
    while (!a_ov && n < 300) begin
      tick();
      n++;
    end
  endtask
  task automatic send_a();
    a_iv = 1'b1;
    tick();
    a_iv = 1'b0;
  endtask
  task automatic load_abc();
    for (int i = 0; i < 8; i++) a_h[i*64 +: 64] = IV[i];
    a_h[63:0] = a_h[63:0] ^ 64'h01010040;
    a_m = 1024'h636261;
    a_t = 128'd3;
    a_last = 1'b1;
  endtask
  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction
  function automatic logic [511:0] ref_f(input logic [511:0] h, input logic [1023:0] m,
                                         input logic [127:0] t, input logic last);
    logic [63:0] v [16];
    logic [63:0] mw [16];
    logic [63:0] sr;
    logic [511:0] r;
    logic [3:0] sx, sy;
    int a, b, c, d, j;
    for (int i = 0; i < 16; i++) mw[i] = m[i*64 +: 64];
    for (int i = 0; i < 8; i++) begin
      v[i] = h[i*64 +: 64];
      v[i + 8] = IV[i];
    end
    v[12] = v[12] ^ t[63:0];
    v[13] = v[13] ^ t[127:64];
    if (last) v[14] = ~v[14];
    for (int rd = 0; rd < 12; rd++) begin
      sr = SG[rd % 10];
      for (int k = 0; k < 8; k++) begin
        j = k % 4;
        a = j;
        b = 4 + ((k < 4) ? j : (j + 1) % 4);
        c = 8 + ((k < 4) ? j : (j + 2) % 4);
        d = 12 + ((k < 4) ? j : (j + 3) % 4);
        sx = 4'(sr >> (60 - 8 * k));
        sy = 4'(sr >> (56 - 8 * k));
        v[a] = v[a] + v[b] + mw[sx];
        v[d] = ror64(v[d] ^ v[a], 32);
        v[c] = v[c] + v[d];
        v[b] = ror64(v[b] ^ v[c], 24);
        v[a] = v[a] + v[b] + mw[sy];
        v[d] = ror64(v[d] ^ v[a], 16);
        v[c] = v[c] + v[d];
        v[b] = ror64(v[b] ^ v[c], 63);
      end
    end
    for (int i = 0; i < 8; i++) r[i*64 +: 64] = h[i*64 +: 64] ^ v[i] ^ v[i + 8];
    return r;
  endfunction
  initial begin
    #500000;
    $display("FAIL watchdog expired before the summary");
    $fatal(1);
  end
  initial begin
    int n, l1, l2, ls, pulses;
    logic [511:0] h1, h2, exp_h;
    logic [255:0] hs;
    rst = 1'b1;
    a_iv = 1'b0;
    a_or = 1'b0;
    s_iv = 1'b0;
    load_abc();
    for (int i = 0; i < 8; i++) b_h[i*32 +: 32] = IV[i][63:32];
    b_h[31:0] = b_h[31:0] ^ 32'h01010020;
    b_m = 512'h636261;
    b_t = 64'd3;
    tick();
    tick();
    check("rst_in_ready", {a_ir, g1_ir, g2_ir, s_ir}, 4'hF);
    check("rst_out_valid", {a_ov, g1_ov, g2_ov, s_ov}, 4'h0);
    check("rst_h_out", a_ho, '0);
    check("rst_cmp_cnt", {a_cnt, g1_cnt, g2_cnt, s_cnt}, '0);
    rst = 1'b0;
    // latency sweep and BLAKE2s run concurrently on the auxiliary instances
    s_iv = 1'b1;
    tick();
    s_iv = 1'b0;
    l1 = 0; l2 = 0; ls = 0;
    h1 = '0; h2 = '0; hs = '0;
    for (int c = 1; c <= 120; c++) begin
      tick();
      if (g1_ov && l1 == 0) begin l1 = c; h1 = g1_ho; end
      if (g2_ov && l2 == 0) begin l2 = c; h2 = g2_ho; end
      if (s_ov && ls == 0) begin ls = c; hs = s_ho; end
    end
    check("g1_latency", l1, 97);
    check("g2_latency", l2, 49);
    check("s_latency", ls, 21);
    check("g1_h_out", h1, ABC_B);
    check("g2_h_out", h2, ABC_B);
    check("s_h0", hs[31:0], 32'h8C5E8C50);
    check("s_h_out", hs, ABC_B[255:0] ^ ABC_B[255:0] ^ ABC_S);
    // BLAKE2b "abc" on the main instance, then hold it under backpressure
    check("abc_in_ready", a_ir, 1'b1);
    send_a();
    check("run_in_ready", a_ir, 1'b0);
    wait_out(n);
    check("abc_latency", n, 25);
    check("abc_h0", a_ho[63:0], 64'h0D4D1C983FA580BA);
    check("abc_h_out", a_ho, ABC_B);
    a_h = ~a_h;
    a_m = {16{64'h5555aaaa33cc0ff0}};
    for (int i = 0; i < 5; i++) begin
      a_iv = (i == 2);
      tick();
      check("bp_out_valid", a_ov, 1'b1);
      check("bp_h_out", a_ho, ABC_B);
      check("bp_in_ready", a_ir, 1'b0);
    end
    a_iv = 1'b0;
    a_or = 1'b1;
    tick();
    a_or = 1'b0;
    check("hs_out_valid", a_ov, 1'b0);
    check("hs_in_ready", a_ir, 1'b1);
    check("hs_cmp_cnt", a_cnt, CNT_EN ? 32'd1 : 32'd0);
    repeat (3) tick();
    check("bp_not_captured", {a_ir, a_ov}, 2'b10);
    // reset in the middle of a block
    load_abc();
    send_a();
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_out_valid", a_ov, 1'b0);
    check("mid_rst_in_ready", a_ir, 1'b1);
    check("mid_rst_h_out", a_ho, '0);
    check("mid_rst_cmp_cnt", a_cnt, '0);
    pulses = 0;
    repeat (40) begin
      tick();
      if (a_ov) pulses++;
    end
    check("aborted_pulses", pulses, 0);
    send_a();
    wait_out(n);
    check("post_rst_latency", n, 25);
    check("post_rst_h_out", a_ho, ABC_B);
    a_or = 1'b1;
    tick();
    a_or = 1'b0;
    // three chained blocks against the reference model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) a_h[i*64 +: 64] = IV[i];
    a_h[63:0] = a_h[63:0] ^ 64'h01010040;
    exp_h = a_h;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 16; j++) a_m[j*64 +: 64] = 64'h0123456789ABCDEF * 64'(k * 16 + j + 1);
      a_t = 128'(128 * (k + 1));
      a_last = (k == 2);
      exp_h = ref_f(exp_h, a_m, a_t, a_last);
      send_a();
      wait_out(n);
      check("chain_latency", n, 25);
      check("chain_h_out", a_ho, exp_h);
      a_h = a_ho;
      a_or = 1'b1;
      tick();
      a_or = 1'b0;
    end
    check("chain_cmp_cnt", a_cnt, CNT_EN ? 32'd3 : 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
